// File: rtl/trivium_xor_stage.sv
// Packs the serial Trivium keystream LSB-first into bytes, buffers them in a small FIFO
// and XORs each one with a plaintext byte. Optional ct_par output when CT_PARITY_EN is defined.
module trivium_xor_stage #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] msg_len,
   input  logic             ks_valid,
   input  logic             ks_bit,
   output logic             ks_ready,
   input  logic             pt_valid,
   input  logic [7:0]       pt_data,
   output logic             pt_ready,
   output logic             ct_valid,
   output logic [7:0]       ct_data,
   output logic             ct_last,
   input  logic             ct_ready,
`ifdef CT_PARITY_EN
   output logic             ct_par,
`endif
   output logic             busy,
   output logic             done
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic {IDLE, RUN} state_e;

   state_e                          state_q, state_d;
   logic [LEN_W-1:0]                len_q, len_d;
   logic [LEN_W-1:0]                ks_byte_cnt_q, ks_byte_cnt_d;
   logic [LEN_W-1:0]                ct_byte_cnt_q, ct_byte_cnt_d;
   logic [2:0]                      bit_idx_q, bit_idx_d;
   logic [7:0]                      shift_q, shift_d;
   logic [FIFO_DEPTH-1:0][7:0]      fifo_mem_q, fifo_mem_d;
   logic [AW:0]                     wr_ptr_q, wr_ptr_d;
   logic [AW:0]                     rd_ptr_q, rd_ptr_d;
   logic                            ct_valid_q, ct_valid_d;
   logic [7:0]                      ct_data_q, ct_data_d;
   logic                            ct_last_q, ct_last_d;
   logic                            done_q, done_d;
`ifdef CT_PARITY_EN
   logic                            ct_par_q, ct_par_d;
`endif

   logic run, fifo_empty, fifo_full, ks_fire, pt_fire;

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      ks_byte_cnt_d = ks_byte_cnt_q;
      ct_byte_cnt_d = ct_byte_cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      fifo_mem_d    = fifo_mem_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      ct_valid_d    = ct_valid_q;
      ct_data_d     = ct_data_q;
      ct_last_d     = ct_last_q;
      done_d        = 1'b0;

      run        = (state_q == RUN);
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      // Extra pointer bit distinguishes full from empty when the index bits match.
      fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      ks_ready   = run && (ks_byte_cnt_q < len_q) && !fifo_full;
      pt_ready   = run && !fifo_empty && (!ct_valid_q || ct_ready);
      ks_fire    = ks_valid && ks_ready;
      pt_fire    = pt_valid && pt_ready;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (msg_len != '0) begin
                  state_d       = RUN;
                  len_d         = msg_len;
                  ks_byte_cnt_d = '0;
                  ct_byte_cnt_d = '0;
                  bit_idx_d     = '0;
                  shift_d       = '0;
                  wr_ptr_d      = '0;
                  rd_ptr_d      = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (ks_fire) begin
               shift_d[bit_idx_q] = ks_bit;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  fifo_mem_d[wr_ptr_q[AW-1:0]] = {ks_bit, shift_q[6:0]};
                  wr_ptr_d      = wr_ptr_q + 1'b1;
                  ks_byte_cnt_d = ks_byte_cnt_q + LEN_W'(1);
               end
            end
            if (pt_fire) begin
               rd_ptr_d      = rd_ptr_q + 1'b1;
               ct_valid_d    = 1'b1;
               ct_data_d     = pt_data ^ fifo_mem_q[rd_ptr_q[AW-1:0]];
               ct_last_d     = (ct_byte_cnt_q == len_q - LEN_W'(1));
               ct_byte_cnt_d = ct_byte_cnt_q + LEN_W'(1);
            end else if (ct_ready) begin
               ct_valid_d = 1'b0;
               ct_last_d  = 1'b0;
            end
            if (ct_valid_q && ct_ready && ct_last_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef CT_PARITY_EN
      ct_par_d = ^ct_data_d;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         len_q         <= '0;
         ks_byte_cnt_q <= '0;
         ct_byte_cnt_q <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         fifo_mem_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         ct_valid_q    <= 1'b0;
         ct_data_q     <= '0;
         ct_last_q     <= 1'b0;
         done_q        <= 1'b0;
`ifdef CT_PARITY_EN
         ct_par_q      <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         ks_byte_cnt_q <= ks_byte_cnt_d;
         ct_byte_cnt_q <= ct_byte_cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         fifo_mem_q    <= fifo_mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         ct_valid_q    <= ct_valid_d;
         ct_data_q     <= ct_data_d;
         ct_last_q     <= ct_last_d;
         done_q        <= done_d;
`ifdef CT_PARITY_EN
         ct_par_q      <= ct_par_d;
`endif
      end
   end

   assign ct_valid = ct_valid_q;
   assign ct_data  = ct_data_q;
   assign ct_last  = ct_last_q;
   assign busy     = (state_q == RUN);
   assign done     = done_q;
`ifdef CT_PARITY_EN
   assign ct_par   = ct_par_q;
`endif

endmodule

// File: doc/trivium_xor_stage.md
# trivium_xor_stage

Downstream consumer of the Trivium keystream generator. Accepts the serial keystream one bit per handshake, packs it LSB-first into bytes and buffers them in a small FIFO. Each byte is XORed with a plaintext byte to produce ciphertext on a registered valid/ready output, for a message length set at start. Sits between the keystream generator and the byte-wide data path.

## Interface
- FIFO_DEPTH, 4, keystream byte FIFO entries; power of two, ≥2
- LEN_W, 12, width of message length / byte counters
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clock clk
- start  in  1  1-cycle pulse; latches msg_len, begins message (ignored while busy)
- msg_len  in  LEN_W  message length in bytes
- ks_valid  in  1  keystream bit valid
- ks_bit  in  1  keystream bit
- ks_ready  out  1  stage accepts keystream bit
- pt_valid  in  1  plaintext byte valid
- pt_data  in  8  plaintext byte
- pt_ready  out  1  plaintext byte accepted this cycle
- ct_valid  out  1  ciphertext byte valid (registered)
- ct_data  out  8  ciphertext byte (registered)
- ct_last  out  1  qualifies final byte of message
- ct_ready  in  1  downstream accepts ciphertext
- busy  out  1  high in RUN
- done  out  1  1-cycle pulse at message end

## Operation
- States: IDLE, RUN.
- IDLE: start with msg_len≠0 → RUN; counters and packer cleared, len latched. start with msg_len=0 → stay IDLE, done pulses next cycle.
- Packer: 3-bit bit index, 8-bit shift. Accepted bit k of a byte lands at bit position k (first bit = LSB). Bit 7 accepted → byte pushed to FIFO, index → 0, ks_byte_cnt +1.
- ks_ready = RUN && ks_byte_cnt < len && FIFO not full. No keystream consumed beyond len bytes; no byte lost.
- pt_ready = RUN && FIFO not empty && (!ct_valid || ct_ready). On pt_valid && pt_ready: pop FIFO, ct_data ← pt_data ^ head, ct_valid ← 1, ct_last ← (ct_byte_cnt == len−1), ct_byte_cnt +1.
- ct_valid/ct_data/ct_last held stable until ct_ready; cleared when ct_ready and no new byte loaded same cycle.
- Simultaneous FIFO push and pop: both occur; occupancy unchanged. Push to full never occurs (ks_ready gating).
- RUN → IDLE on handshake of the ct_last byte; done pulses the following cycle; busy low from that cycle.
- Counters LEN_W wide, no wrap (bounded by len).
- Reset: async; state IDLE, FIFO empty, partial bits discarded, all counters 0.

## Timing
- Reset values: ks_ready 0, pt_ready 0, ct_valid 0, ct_data 0x00, ct_last 0, busy 0, done 0.
- start at cycle 0 → busy and ks_ready high cycle 1.
- 8 bits accepted in cycles 1–8 → FIFO non-empty cycle 9 → pt_ready high cycle 9 → ct_valid high cycle 10 (pt_valid high).
- Full throughput: 1 ct byte per 8 cycles (keystream-bound); FIFO lets keystream run ahead by FIFO_DEPTH bytes under backpressure.
- pt_ready, ks_ready combinational from registered state; no combinational path from ks_valid/pt_valid to any ready.
- Reset mid-message: outputs at reset values same cycle as assertion (async); no done pulse.

## Configuration
- CT_PARITY_EN defined: extra output ct_par (1 bit), registered with ct_data, = XOR of all 8 ct_data bits, 0 at reset.
- Not defined: port absent; behaviour otherwise identical.

## Test plan
- msg_len=1, ks bits 1,0,1,1,0,0,0,0, pt 0xFF, ct_ready=1 → ct_data 0xF2, ct_last 1, ct_valid at cycle 10, done one cycle after handshake; ct_par=1 with CT_PARITY_EN.
- msg_len=3, keystream all ones, pt 0x00,0x55,0xA5 → ct 0xFF,0xAA,0x5A; ct_last only on third; ks_ready low after 24 bits.
- msg_len=8, ct_ready=0 throughout, ks_valid=1, FIFO_DEPTH=4 → one byte in output register, 4 in FIFO, ks_ready low after 40 bits; ct_data stable; release ct_ready → all 8 bytes in order.
- start with msg_len=0 → busy stays 0, ks_ready stays 0, done pulse next cycle; start while busy ignored (len unchanged).
- Reset asserted after 13 bits of msg_len=4 → all outputs reset immediately; new start with msg_len=1 and bits 1,0,1,1,0,0,0,0, pt 0xFF → 0xF2 (no stale bits).
